// File: rtl/cv32e40p_cg_pkg.sv
// Shared types and defaults for the core clock-gate enable controller.
package cv32e40p_cg_pkg;

    typedef enum logic [1:0] {
        CG_RUN,
        CG_DRAIN,
        CG_SLEEP,
        CG_WAKE
    } cg_state_e;

    localparam int unsigned CG_IDLE_CYCLES_DEF = 4;
    localparam int unsigned CG_WAKE_CYCLES_DEF = 2;
    localparam int unsigned CG_STAT_W          = 32;

endpackage

// File: rtl/cv32e40p_cg_stat_counter.sv
// Saturating up-counter used for gated-cycle statistics; cleared only by reset.
module cv32e40p_cg_stat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_cg_enable_ctrl.sv
// Clock-gate enable controller on the free-running clock: RUN/DRAIN/SLEEP/WAKE with hysteresis.
// Optional gated-cycle statistics are built when CV32E40P_CG_STATS_EN is defined.
module cv32e40p_cg_enable_ctrl
    import cv32e40p_cg_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = CG_IDLE_CYCLES_DEF,
    parameter int unsigned WAKE_CYCLES = CG_WAKE_CYCLES_DEF,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sleep_req_i,
    input  logic                 busy_i,
    input  logic                 wake_i,
    input  logic                 force_en_i,
    output logic                 cg_en_o,
    output logic                 sleep_o,
    output logic                 wake_ack_o,
    output logic [CG_STAT_W-1:0] sleep_cnt_o
);

    if ((IDLE_CYCLES < 1) || (IDLE_CYCLES > (2 ** CNT_W) - 1)) begin : g_idle_chk
        $error("IDLE_CYCLES out of range 1..2^CNT_W-1");
    end
    if ((WAKE_CYCLES < 1) || (WAKE_CYCLES > (2 ** CNT_W) - 1)) begin : g_wake_chk
        $error("WAKE_CYCLES out of range 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    cg_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CG_RUN;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    // Wake sources always win over a sleep request, in RUN and in DRAIN alike.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        unique case (state_q)
            CG_RUN: begin
                if (sleep_req_i && !busy_i && !wake_i && !force_en_i) begin
                    state_d = CG_DRAIN;
                    cnt_d   = '0;
                end
            end
            CG_DRAIN: begin
                if (busy_i || wake_i || force_en_i || !sleep_req_i) begin
                    state_d = CG_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == IDLE_LAST) begin
                        state_d = CG_SLEEP;
                    end
                end
            end
            CG_SLEEP: begin
                if (wake_i || force_en_i) begin
                    state_d = CG_WAKE;
                    cnt_d   = '0;
                end
            end
            CG_WAKE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == WAKE_LAST) begin
                    state_d = CG_RUN;
                    ack_d   = 1'b1;
                end
            end
            default: state_d = CG_RUN;
        endcase
    end

    assign cg_en_o    = (state_q != CG_SLEEP);
    assign sleep_o    = (state_q == CG_SLEEP);
    assign wake_ack_o = ack_q;

`ifdef CV32E40P_CG_STATS_EN
    cv32e40p_cg_stat_counter #(
        .W(CG_STAT_W)
    ) u_stat (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .inc_i(state_q == CG_SLEEP),
        .cnt_o(sleep_cnt_o)
    );
`else
    assign sleep_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_cg_enable_ctrl.sv
// Scoreboard bench for cv32e40p_cg_enable_ctrl: directed scenarios plus random traffic vs. a timeline model.
module tb_cv32e40p_cg_enable_ctrl;

    localparam int IDLE_N = 4;
    localparam int WAKE_N = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sleep_req = 1'b0;
    logic        busy = 1'b0;
    logic        wake = 1'b0;
    logic        force_en = 1'b0;
    logic        cg_en;
    logic        sleep;
    logic        wake_ack;
    logic [31:0] sleep_cnt;

    always #5 clk = ~clk;

    cv32e40p_cg_enable_ctrl #(
        .IDLE_CYCLES(IDLE_N),
        .WAKE_CYCLES(WAKE_N),
        .CNT_W(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .sleep_req_i(sleep_req),
        .busy_i(busy),
        .wake_i(wake),
        .force_en_i(force_en),
        .cg_en_o(cg_en),
        .sleep_o(sleep),
        .wake_ack_o(wake_ack),
        .sleep_cnt_o(sleep_cnt)
    );

    typedef struct {
        logic        cg_en;
        logic        sleep;
        logic        ack;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Timeline model: idle_run counts qualifying drain cycles (-1 = not draining),
    // wake_left counts settle cycles still to run after a wake.
    int          idle_run  = -1;
    bit          asleep    = 0;
    int          wake_left = 0;
    bit          ack_now   = 0;
    longint      stat      = 0;
    string       cur_tag   = "reset";

    task automatic model_edge(input bit r, input bit s, input bit b, input bit w, input bit f);
        ack_now = 0;
        if (r) begin
            idle_run  = -1;
            asleep    = 0;
            wake_left = 0;
            stat      = 0;
        end else begin
            if (asleep && stat < 64'hFFFF_FFFF) stat++;
            if (asleep) begin
                if (w || f) begin
                    asleep    = 0;
                    wake_left = WAKE_N;
                end
            end else if (wake_left > 0) begin
                wake_left--;
                if (wake_left == 0) ack_now = 1;
            end else if (idle_run >= 0) begin
                if (b || w || f || !s) begin
                    idle_run = -1;
                end else begin
                    idle_run++;
                    if (idle_run == IDLE_N) begin
                        asleep   = 1;
                        idle_run = -1;
                    end
                end
            end else if (s && !b && !w && !f) begin
                idle_run = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit b, input bit w, input bit f);
        exp_t e;
        @(negedge clk);
        rst = r; sleep_req = s; busy = b; wake = w; force_en = f;
        @(posedge clk);
        model_edge(r, s, b, w, f);
        e.cg_en = !asleep;
        e.sleep = asleep;
        e.ack   = ack_now;
`ifdef CV32E40P_CG_STATS_EN
        e.cnt   = stat[31:0];
`else
        e.cnt   = 32'h0;
`endif
        e.tag   = cur_tag;
        exp_q.push_back(e);
    endtask

    task automatic steps(input int n, input bit s, input bit b, input bit w, input bit f);
        for (int i = 0; i < n; i++) step(0, s, b, w, f);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".cg_en"},    32'(cg_en),    32'(e.cg_en));
                chk({e.tag, ".sleep"},    32'(sleep),    32'(e.sleep));
                chk({e.tag, ".wake_ack"}, 32'(wake_ack), 32'(e.ack));
                chk({e.tag, ".sleep_cnt"}, sleep_cnt,    e.cnt);
            end
        end
    end

    initial begin : stim
        cur_tag = "reset";
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        cur_tag = "basic";
        steps(5, 0, 0, 0, 0);
        steps(15, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        steps(6, 1, 0, 0, 0);
        steps(4, 0, 0, 0, 0);

        cur_tag = "abort";
        steps(2, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        steps(8, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        steps(4, 0, 0, 0, 0);

        cur_tag = "simul";
        steps(12, 1, 0, 1, 0);
        steps(3, 0, 0, 0, 0);

        cur_tag = "force";
        steps(7, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1);
        steps(4, 0, 0, 0, 0);
        steps(12, 1, 0, 0, 1);
        steps(3, 0, 0, 0, 0);

        cur_tag = "rst_sleep";
        steps(7, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        steps(6, 0, 0, 0, 0);
        steps(7, 1, 0, 1, 0);
        steps(2, 0, 0, 0, 0);

        cur_tag = "rst_wake";
        steps(7, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        steps(5, 0, 0, 0, 0);

        cur_tag = "stat100";
        steps(6, 1, 0, 0, 0);
        steps(100, 1, 0, 0, 0);
`ifdef CV32E40P_CG_STATS_EN
        cur_tag = "stat_sat";
        #2;
        dut.u_stat.cnt_q = 32'hFFFF_FFFC;
        stat = 64'hFFFF_FFFC;
        steps(8, 1, 1, 0, 0);
`endif
        step(0, 0, 0, 1, 0);
        steps(4, 0, 0, 0, 0);

        cur_tag = "random";
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 59) == 0));
        end

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
